// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM stage controller: control bit positions,
// FSM states, timeout default and the registered bundle layouts.
package mem_stage_ctrl_pkg;

  localparam int unsigned M_BRANCH   = 2;
  localparam int unsigned M_MEMREAD  = 1;
  localparam int unsigned M_MEMWRITE = 0;
  localparam int unsigned ZERO_BIT   = 0;

  localparam int unsigned TIMEOUT_DEFAULT = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Memory op captured on ACCESS entry so the bus stays stable until completion.
  typedef struct packed {
    logic [1:0]  wb;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  regdst;
  } mem_req_t;

  typedef struct packed {
    logic [1:0]  wb;
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [4:0]  regdst;
  } mem_wb_t;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data memory port: controller drives the request side (master), memory
// returns load data and completion (slave).
interface mem_stage_ctrl_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/mem_timeout_counter.sv
// Access timeout counter: clear wins over enable; expired is combinational
// from the count and the count saturates at the limit.
module mem_timeout_counter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count_q;

  assign expired = (count_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: runs data memory accesses with a pipeline stall,
// registers the MEM/WB bundle and aborts accesses that exceed TIMEOUT cycles.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           in_WB,
  input  logic [2:0]           in_M,
  input  logic [7:0]           in_jump_address,
  input  logic [7:0]           in_ALU_status,
  input  logic [31:0]          in_ALU_result,
  input  logic [31:0]          in_write_data,
  input  logic [4:0]           in_RegDst_address,
  mem_stage_ctrl_if.master     dmem,
  output logic                 stall,
  output logic                 pc_src,
  output logic [7:0]           branch_target,
  output logic [1:0]           wb_WB,
  output logic [31:0]          wb_read_data,
  output logic [31:0]          wb_ALU_result,
  output logic [4:0]           wb_RegDst_address,
  output logic                 mem_err
);

  state_e   state_q;
  mem_req_t hold_q;
  mem_wb_t  wb_q;
  logic     mem_err_q;

  logic rd_op, wr_op, aligned, op_ok, op_err;
  logic cnt_clear, cnt_enable, expired;
  logic unused_status;

  assign rd_op   = in_M[M_MEMREAD];
  assign wr_op   = in_M[M_MEMWRITE];
  assign aligned = (in_ALU_result[1:0] == 2'b00);
  assign op_ok   = (rd_op ^ wr_op) && aligned;
  assign op_err  = (rd_op || wr_op) && !op_ok;

  assign unused_status = ^in_ALU_status[7:1];

  assign cnt_clear  = (state_q == IDLE) && op_ok;
  assign cnt_enable = (state_q == ACCESS) && !dmem.dmem_ready;

  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .expired (expired)
  );

  assign dmem.dmem_req   = (state_q == ACCESS);
  assign dmem.dmem_we    = hold_q.we;
  assign dmem.dmem_addr  = hold_q.addr;
  assign dmem.dmem_wdata = hold_q.wdata;

  always_comb begin
    stall = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE:    stall = op_ok;
        // An aborting access releases the pipeline on its last cycle.
        ACCESS:  stall = !dmem.dmem_ready && !expired;
        default: stall = 1'b0;
      endcase
    end
  end

  assign pc_src = !reset && (state_q == IDLE) &&
                  in_M[M_BRANCH] && in_ALU_status[ZERO_BIT];
  assign branch_target = in_jump_address;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      wb_q      <= '0;
      mem_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (op_ok) begin
            hold_q  <= '{wb: in_WB, we: wr_op, addr: in_ALU_result,
                         wdata: in_write_data, regdst: in_RegDst_address};
            state_q <= ACCESS;
          end else if (op_err) begin
            wb_q      <= '0;
            mem_err_q <= 1'b1;
          end else begin
            wb_q <= '{wb: in_WB, read_data: 32'd0, alu_result: in_ALU_result,
                      regdst: in_RegDst_address};
          end
        end
        ACCESS: begin
          // Ready on the limit cycle still completes the access.
          if (dmem.dmem_ready) begin
            wb_q    <= '{wb: hold_q.wb,
                         read_data: hold_q.we ? 32'd0 : dmem.dmem_rdata,
                         alu_result: hold_q.addr, regdst: hold_q.regdst};
            state_q <= IDLE;
          end else if (expired) begin
            wb_q      <= '0;
            mem_err_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb_WB             = wb_q.wb;
  assign wb_read_data      = wb_q.read_data;
  assign wb_ALU_result     = wb_q.alu_result;
  assign wb_RegDst_address = wb_q.regdst;
  assign mem_err           = mem_err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: inputs change on the falling edge and
// outputs are sampled 1ns later, well away from the rising edge.
module tb_mem_stage_ctrl;

  logic        clk;
  logic        reset;
  logic [1:0]  in_WB;
  logic [2:0]  in_M;
  logic [7:0]  in_jump_address;
  logic [7:0]  in_ALU_status;
  logic [31:0] in_ALU_result;
  logic [31:0] in_write_data;
  logic [4:0]  in_RegDst_address;
  logic        stall;
  logic        pc_src;
  logic [7:0]  branch_target;
  logic [1:0]  wb_WB;
  logic [31:0] wb_read_data;
  logic [31:0] wb_ALU_result;
  logic [4:0]  wb_RegDst_address;
  logic        mem_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage_ctrl_if dmem_if ();

  mem_stage_ctrl #(.TIMEOUT(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_WB             (in_WB),
    .in_M              (in_M),
    .in_jump_address   (in_jump_address),
    .in_ALU_status     (in_ALU_status),
    .in_ALU_result     (in_ALU_result),
    .in_write_data     (in_write_data),
    .in_RegDst_address (in_RegDst_address),
    .dmem              (dmem_if),
    .stall             (stall),
    .pc_src            (pc_src),
    .branch_target     (branch_target),
    .wb_WB             (wb_WB),
    .wb_read_data      (wb_read_data),
    .wb_ALU_result     (wb_ALU_result),
    .wb_RegDst_address (wb_RegDst_address),
    .mem_err           (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_op(input logic [2:0] m, input logic [1:0] wb,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd);
    in_M              = m;
    in_WB             = wb;
    in_ALU_result     = addr;
    in_write_data     = wdata;
    in_RegDst_address = rd;
    in_ALU_status     = 8'h00;
  endtask

  task automatic drive_nop();
    drive_op(3'b000, 2'b01, 32'h0000_5555, 32'h0, 5'd3);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    drive_op(3'b110, 2'b11, 32'h40, 32'h0, 5'd1);
    in_ALU_status   = 8'h01;
    in_jump_address = 8'h22;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_checks++; if (pc_src !== 1'b0) begin n_fail++; $display("FAIL reset_pc_src: got %b want 0", pc_src); end
    @(negedge clk);
    #1;
    n_checks++; if (wb_WB !== 2'b00) begin n_fail++; $display("FAIL reset_wb_WB: got %b want 00", wb_WB); end
    n_checks++; if (wb_ALU_result !== 32'h0) begin n_fail++; $display("FAIL reset_wb_alu: got %h want 0", wb_ALU_result); end
    n_checks++; if (wb_read_data !== 32'h0) begin n_fail++; $display("FAIL reset_wb_rdata: got %h want 0", wb_read_data); end
    n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL reset_mem_err: got %b want 0", mem_err); end
    n_checks++; if (dmem_if.dmem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", dmem_if.dmem_req); end
    drive_nop();
    in_jump_address = 8'h00;
    reset = 1'b0;
  endtask

  task automatic test_alu();
    @(negedge clk);
    drive_op(3'b000, 2'b10, 32'h1234, 32'hFFFF_0000, 5'd5);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b want 0", stall); end
    n_checks++; if (dmem_if.dmem_req !== 1'b0) begin n_fail++; $display("FAIL alu_req: got %b want 0", dmem_if.dmem_req); end
    @(negedge clk);
    #1;
    n_checks++; if (wb_ALU_result !== 32'h1234) begin n_fail++; $display("FAIL alu_result: got %h want 1234", wb_ALU_result); end
    n_checks++; if (wb_RegDst_address !== 5'd5) begin n_fail++; $display("FAIL alu_regdst: got %0d want 5", wb_RegDst_address); end
    n_checks++; if (wb_WB !== 2'b10) begin n_fail++; $display("FAIL alu_wb: got %b want 10", wb_WB); end
    n_checks++; if (wb_read_data !== 32'h0) begin n_fail++; $display("FAIL alu_rdata: got %h want 0", wb_read_data); end
  endtask

  // Follows test_alu directly, so MEM/WB still shows the ALU bundle while stalled.
  task automatic test_load();
    int stalls = 0;
    drive_op(3'b010, 2'b11, 32'h40, 32'h0, 5'd7);
    dmem_if.dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 3) begin
        dmem_if.dmem_ready = 1'b1;
        dmem_if.dmem_rdata = 32'hDEAD_BEEF;
      end
      #1;
      if (stall) stalls++;
      if (i == 0) begin
        n_checks++; if (dmem_if.dmem_req !== 1'b0) begin n_fail++; $display("FAIL load_idle_req: got %b want 0", dmem_if.dmem_req); end
      end
      if (i == 2) begin
        n_checks++; if (dmem_if.dmem_req !== 1'b1) begin n_fail++; $display("FAIL load_req: got %b want 1", dmem_if.dmem_req); end
        n_checks++; if (dmem_if.dmem_we !== 1'b0) begin n_fail++; $display("FAIL load_we: got %b want 0", dmem_if.dmem_we); end
        n_checks++; if (dmem_if.dmem_addr !== 32'h40) begin n_fail++; $display("FAIL load_addr: got %h want 40", dmem_if.dmem_addr); end
        n_checks++; if (wb_ALU_result !== 32'h1234) begin n_fail++; $display("FAIL load_wb_hold: got %h want 1234", wb_ALU_result); end
      end
    end
    n_checks++; if (stalls != 3) begin n_fail++; $display("FAIL load_stall_cycles: got %0d want 3", stalls); end
    @(negedge clk);
    dmem_if.dmem_ready = 1'b0;
    #1;
    n_checks++; if (wb_read_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_rdata: got %h want deadbeef", wb_read_data); end
    n_checks++; if (wb_RegDst_address !== 5'd7) begin n_fail++; $display("FAIL load_regdst: got %0d want 7", wb_RegDst_address); end
    n_checks++; if (dmem_if.dmem_req !== 1'b0) begin n_fail++; $display("FAIL load_req_done: got %b want 0", dmem_if.dmem_req); end
    drive_nop();
  endtask

  task automatic test_store();
    int stalls = 0;
    @(negedge clk);
    drive_op(3'b001, 2'b00, 32'h80, 32'hCAFE_0001, 5'd0);
    #1;
    if (stall) stalls++;
    @(negedge clk);
    dmem_if.dmem_ready = 1'b1;
    dmem_if.dmem_rdata = 32'h1111_2222;
    #1;
    if (stall) stalls++;
    n_checks++; if (dmem_if.dmem_we !== 1'b1) begin n_fail++; $display("FAIL store_we: got %b want 1", dmem_if.dmem_we); end
    n_checks++; if (dmem_if.dmem_wdata !== 32'hCAFE_0001) begin n_fail++; $display("FAIL store_wdata: got %h want cafe0001", dmem_if.dmem_wdata); end
    n_checks++; if (dmem_if.dmem_addr !== 32'h80) begin n_fail++; $display("FAIL store_addr: got %h want 80", dmem_if.dmem_addr); end
    n_checks++; if (stalls != 1) begin n_fail++; $display("FAIL store_stall_cycles: got %0d want 1", stalls); end
    @(negedge clk);
    dmem_if.dmem_ready = 1'b0;
    #1;
    n_checks++; if (wb_read_data !== 32'h0) begin n_fail++; $display("FAIL store_rdata: got %h want 0", wb_read_data); end
    n_checks++; if (wb_ALU_result !== 32'h80) begin n_fail++; $display("FAIL store_result: got %h want 80", wb_ALU_result); end
    drive_nop();
  endtask

  task automatic test_ready_at_limit();
    int acc = 0;
    @(negedge clk);
    drive_op(3'b010, 2'b10, 32'h300, 32'h0, 5'd12);
    for (int i = 0; i < 40 && acc < 16; i++) begin
      @(negedge clk);
      #1;
      if (dmem_if.dmem_req) acc++;
    end
    n_checks++; if (acc != 16) begin n_fail++; $display("FAIL limit_reach: got %0d access cycles want 16", acc); end
    dmem_if.dmem_ready = 1'b1;
    dmem_if.dmem_rdata = 32'h600D_F00D;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL limit_stall: got %b want 0", stall); end
    @(negedge clk);
    dmem_if.dmem_ready = 1'b0;
    #1;
    n_checks++; if (wb_read_data !== 32'h600D_F00D) begin n_fail++; $display("FAIL limit_rdata: got %h want 600df00d", wb_read_data); end
    n_checks++; if (wb_WB !== 2'b10) begin n_fail++; $display("FAIL limit_wb: got %b want 10", wb_WB); end
    n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL limit_mem_err: got %b want 0", mem_err); end
    drive_nop();
  endtask

  task automatic test_branch();
    @(negedge clk);
    drive_op(3'b100, 2'b00, 32'h0, 32'h0, 5'd0);
    in_ALU_status   = 8'h01;
    in_jump_address = 8'h3C;
    #1;
    n_checks++; if (pc_src !== 1'b1) begin n_fail++; $display("FAIL branch_taken: got %b want 1", pc_src); end
    n_checks++; if (branch_target !== 8'h3C) begin n_fail++; $display("FAIL branch_target: got %h want 3c", branch_target); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL branch_stall: got %b want 0", stall); end
    in_ALU_status = 8'hFE;
    #1;
    n_checks++; if (pc_src !== 1'b0) begin n_fail++; $display("FAIL branch_not_taken: got %b want 0", pc_src); end
    drive_nop();
  endtask

  task automatic test_timeout();
    int  acc = 0;
    logic seen_abort = 1'b0;
    @(negedge clk);
    drive_op(3'b010, 2'b11, 32'h100, 32'h0, 5'd9);
    for (int i = 0; i < 40 && !seen_abort; i++) begin
      @(negedge clk);
      #1;
      if (dmem_if.dmem_req) acc++;
      if (dmem_if.dmem_req && !stall) seen_abort = 1'b1;
    end
    n_checks++; if (seen_abort !== 1'b1) begin n_fail++; $display("FAIL timeout_seen: got %b want 1", seen_abort); end
    n_checks++; if (acc != 16) begin n_fail++; $display("FAIL timeout_cycles: got %0d want 16", acc); end
    drive_nop();
    @(negedge clk);
    #1;
    n_checks++; if (wb_WB !== 2'b00) begin n_fail++; $display("FAIL timeout_wb: got %b want 00", wb_WB); end
    n_checks++; if (mem_err !== 1'b1) begin n_fail++; $display("FAIL timeout_mem_err: got %b want 1", mem_err); end
    n_checks++; if (dmem_if.dmem_req !== 1'b0) begin n_fail++; $display("FAIL timeout_req: got %b want 0", dmem_if.dmem_req); end
    @(negedge clk);
    #1;
    n_checks++; if (mem_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", mem_err); end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    drive_op(3'b010, 2'b11, 32'h200, 32'h0, 5'd4);
    @(negedge clk);
    #1;
    n_checks++; if (dmem_if.dmem_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_req: got %b want 1", dmem_if.dmem_req); end
    reset = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall: got %b want 0", stall); end
    @(negedge clk);
    #1;
    n_checks++; if (dmem_if.dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req_drop: got %b want 0", dmem_if.dmem_req); end
    n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_err_clr: got %b want 0", mem_err); end
    reset = 1'b0;
    drive_op(3'b010, 2'b11, 32'h41, 32'h0, 5'd4);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL misalign_stall: got %b want 0", stall); end
    @(negedge clk);
    #1;
    n_checks++; if (mem_err !== 1'b1) begin n_fail++; $display("FAIL misalign_err: got %b want 1", mem_err); end
    n_checks++; if (dmem_if.dmem_req !== 1'b0) begin n_fail++; $display("FAIL misalign_req: got %b want 0", dmem_if.dmem_req); end
    n_checks++; if (wb_WB !== 2'b00) begin n_fail++; $display("FAIL misalign_wb: got %b want 00", wb_WB); end
    drive_nop();
  endtask

  task automatic test_both_set();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive_op(3'b011, 2'b10, 32'h84, 32'h0, 5'd6);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL both_stall: got %b want 0", stall); end
    @(negedge clk);
    #1;
    n_checks++; if (mem_err !== 1'b1) begin n_fail++; $display("FAIL both_err: got %b want 1", mem_err); end
    n_checks++; if (dmem_if.dmem_req !== 1'b0) begin n_fail++; $display("FAIL both_req: got %b want 0", dmem_if.dmem_req); end
    drive_nop();
  endtask

  initial begin
    reset              = 1'b1;
    in_jump_address    = 8'h00;
    dmem_if.dmem_ready = 1'b0;
    dmem_if.dmem_rdata = 32'h0;
    drive_nop();
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_ready_at_limit();
    test_branch();
    test_timeout();
    test_reset_mid_access();
    test_both_set();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
